// File: rtl/sub_chunk_sched_pkg.sv
// Shared state encoding and default sizing for the sub-chunk scheduler.
package sub_chunk_sched_pkg;

  localparam int SUB_CHUNK_NUM_DEF = 4;
  localparam int CHUNK_CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    RUN,
    RELEASE
  } sched_state_e;

endpackage

// File: rtl/chunk_bank_tracker.sv
// Ping-pong full flags and write pointer for one chunk buffer (IFM or filter).
module chunk_bank_tracker (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_done_i,
  input  logic       release_i,
  input  logic       rd_sel_i,
  output logic [1:0] full_o,
  output logic       wr_sel_o,
  output logic       wr_ready_o,
  output logic       err_o
);

  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       err_q, err_d;

  // A write-done into a bank that is still full (even one being released this
  // cycle) is dropped and flagged; the release clears only the read bank.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    err_d    = err_q;
    if (wr_done_i) begin
      if (full_q[wr_sel_q]) begin
        err_d = 1'b1;
      end else begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end
    if (release_i) begin
      full_d[rd_sel_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      err_q    <= err_d;
    end
  end

  // Ready reflects an empty write bank, so it reads 1 straight out of reset.
  assign full_o     = full_q;
  assign wr_sel_o   = wr_sel_q;
  assign wr_ready_o = ~full_q[wr_sel_q];
  assign err_o      = err_q;

endmodule

// File: rtl/sub_chunk_scheduler.sv
// Sequences sub-chunk reads over ping-pong IFM/filter banks and counts chunks to end of layer.
module sub_chunk_scheduler
  import sub_chunk_sched_pkg::*;
#(
  parameter int SUB_CHUNK_NUM = SUB_CHUNK_NUM_DEF,
  parameter int CHUNK_CNT_W   = CHUNK_CNT_W_DEF,
  parameter int SM_ADDR_W     = $clog2(SUB_CHUNK_NUM)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [CHUNK_CNT_W-1:0] cfg_chunk_num_i,
  input  logic [SM_ADDR_W-1:0]   cfg_fil_last_i,
  input  logic                   ifm_wr_done_i,
  input  logic                   fil_wr_done_i,
  input  logic                   sub_chunk_end_i,
  output logic                   ifm_wr_sel_o,
  output logic                   fil_wr_sel_o,
  output logic                   ifm_wr_ready_o,
  output logic                   fil_wr_ready_o,
  output logic                   rd_sel_o,
  output logic                   sub_chunk_start_o,
  output logic                   run_valid_o,
  output logic [SM_ADDR_W-1:0]   rd_fil_last_o,
  output logic                   chunk_done_o,
  output logic                   layer_done_o,
  output logic                   busy_o,
  output logic                   err_o
);

  sched_state_e           state_q, state_d;
  logic [CHUNK_CNT_W-1:0] chunk_cnt_q, chunk_cnt_d;
  logic [CHUNK_CNT_W-1:0] cfg_chunk_q, cfg_chunk_d;
  logic [SM_ADDR_W-1:0]   sub_cnt_q, sub_cnt_d;
  logic [SM_ADDR_W-1:0]   fil_last_q, fil_last_d;
  logic                   rd_sel_q, rd_sel_d;
  logic                   release_bank;
  logic [1:0]             ifm_full, fil_full;
  logic                   ifm_err, fil_err;
  logic                   readable, last_sub, last_chunk;

  chunk_bank_tracker u_ifm_bank (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_done_i  (ifm_wr_done_i),
    .release_i  (release_bank),
    .rd_sel_i   (rd_sel_q),
    .full_o     (ifm_full),
    .wr_sel_o   (ifm_wr_sel_o),
    .wr_ready_o (ifm_wr_ready_o),
    .err_o      (ifm_err)
  );

  chunk_bank_tracker u_fil_bank (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_done_i  (fil_wr_done_i),
    .release_i  (release_bank),
    .rd_sel_i   (rd_sel_q),
    .full_o     (fil_full),
    .wr_sel_o   (fil_wr_sel_o),
    .wr_ready_o (fil_wr_ready_o),
    .err_o      (fil_err)
  );

  assign readable   = ifm_full[rd_sel_q] & fil_full[rd_sel_q];
  assign last_sub   = (sub_cnt_q == SM_ADDR_W'(SUB_CHUNK_NUM - 1));
  assign last_chunk = ((chunk_cnt_q + CHUNK_CNT_W'(1)) == cfg_chunk_q);

  always_comb begin
    state_d           = state_q;
    chunk_cnt_d       = chunk_cnt_q;
    cfg_chunk_d       = cfg_chunk_q;
    sub_cnt_d         = sub_cnt_q;
    fil_last_d        = fil_last_q;
    rd_sel_d          = rd_sel_q;
    release_bank      = 1'b0;
    sub_chunk_start_o = 1'b0;
    run_valid_o       = 1'b0;
    chunk_done_o      = 1'b0;
    layer_done_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          if (cfg_chunk_num_i != '0) begin
            state_d     = WAIT;
            cfg_chunk_d = cfg_chunk_num_i;
            fil_last_d  = cfg_fil_last_i;
            chunk_cnt_d = '0;
            sub_cnt_d   = '0;
          end else begin
            layer_done_o = 1'b1;
          end
        end
      end
      WAIT: begin
        if (readable) state_d = START;
      end
      // An end arriving during the start cycle is accepted just like one in RUN.
      START, RUN: begin
        sub_chunk_start_o = (state_q == START);
        run_valid_o       = 1'b1;
        if (sub_chunk_end_i) begin
          if (last_sub) begin
            state_d = RELEASE;
          end else begin
            sub_cnt_d = sub_cnt_q + SM_ADDR_W'(1);
            state_d   = START;
          end
        end else begin
          state_d = RUN;
        end
      end
      RELEASE: begin
        release_bank = 1'b1;
        rd_sel_d     = ~rd_sel_q;
        sub_cnt_d    = '0;
        chunk_done_o = 1'b1;
        chunk_cnt_d  = chunk_cnt_q + CHUNK_CNT_W'(1);
        if (last_chunk) begin
          layer_done_o = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      chunk_cnt_q <= '0;
      cfg_chunk_q <= '0;
      sub_cnt_q   <= '0;
      fil_last_q  <= '0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_cnt_q <= chunk_cnt_d;
      cfg_chunk_q <= cfg_chunk_d;
      sub_cnt_q   <= sub_cnt_d;
      fil_last_q  <= fil_last_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  assign rd_sel_o      = rd_sel_q;
  assign rd_fil_last_o = fil_last_q;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = ifm_err | fil_err;

endmodule

// File: tb/tb_sub_chunk_scheduler.sv
// Scoreboard bench for sub_chunk_scheduler: expected event stream plus a bank-flag model.
module tb_sub_chunk_scheduler;

  localparam int SUBN    = 4;
  localparam int CW      = 16;
  localparam int AW      = 2;
  localparam int K_START = 0;
  localparam int K_CHUNK = 1;
  localparam int K_LAYER = 2;

  typedef struct {
    int kind;
    int sel;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i, enable_i, ifm_wr_done_i, fil_wr_done_i, sub_chunk_end_i;
  logic [CW-1:0] cfg_chunk_num_i;
  logic [AW-1:0] cfg_fil_last_i;
  logic          ifm_wr_sel_o, fil_wr_sel_o, ifm_wr_ready_o, fil_wr_ready_o, rd_sel_o;
  logic          sub_chunk_start_o, run_valid_o, chunk_done_o, layer_done_o, busy_o, err_o;
  logic [AW-1:0] rd_fil_last_o;

  sub_chunk_scheduler dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .enable_i          (enable_i),
    .cfg_chunk_num_i   (cfg_chunk_num_i),
    .cfg_fil_last_i    (cfg_fil_last_i),
    .ifm_wr_done_i     (ifm_wr_done_i),
    .fil_wr_done_i     (fil_wr_done_i),
    .sub_chunk_end_i   (sub_chunk_end_i),
    .ifm_wr_sel_o      (ifm_wr_sel_o),
    .fil_wr_sel_o      (fil_wr_sel_o),
    .ifm_wr_ready_o    (ifm_wr_ready_o),
    .fil_wr_ready_o    (fil_wr_ready_o),
    .rd_sel_o          (rd_sel_o),
    .sub_chunk_start_o (sub_chunk_start_o),
    .run_valid_o       (run_valid_o),
    .rd_fil_last_o     (rd_fil_last_o),
    .chunk_done_o      (chunk_done_o),
    .layer_done_o      (layer_done_o),
    .busy_o            (busy_o),
    .err_o             (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0, cyc = 0;
  int last_end_cyc = -10, first_start_cyc = -1;
  int n_start = 0, n_layer = 0, mon_sub = 0, sel_cnt = -1, stray_ref = 0;
  bit m_ifm_full[2], m_fil_full[2];
  bit m_ifm_ws, m_fil_ws, m_err, m_rd, rel_pending, run_exp;
  int m_fil_last;
  bit auto_fill, poke, sel_zero, stray_ok;
  exp_t exp_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_expect(input int kind, input int sel);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL event_unexpected: got kind %0d sel %0d, expected no event (cycle %0d)", kind, sel, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind != K_LAYER) chk("event_rd_sel", sel, e.sel);
    end
  endtask

  task automatic model_reset();
    m_ifm_full = '{0, 0};
    m_fil_full = '{0, 0};
    m_ifm_ws = 0; m_fil_ws = 0; m_err = 0; m_rd = 0;
    rel_pending = 0; m_fil_last = 0;
    exp_q.delete();
  endtask

  // Monitor: compares every cycle against the model and pops the event scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        run_exp = 0;
        mon_sub = 0;
      end else begin
        if (sub_chunk_end_i) run_exp = 0;
        if (sub_chunk_start_o) run_exp = 1;
        chk("run_valid", run_valid_o, run_exp);
        chk("ifm_wr_sel", ifm_wr_sel_o, m_ifm_ws);
        chk("fil_wr_sel", fil_wr_sel_o, m_fil_ws);
        chk("ifm_wr_ready", ifm_wr_ready_o, !m_ifm_full[m_ifm_ws]);
        chk("fil_wr_ready", fil_wr_ready_o, !m_fil_full[m_fil_ws]);
        chk("err", err_o, m_err);
        chk("rd_sel", rd_sel_o, m_rd);
        chk("rd_fil_last", rd_fil_last_o, m_fil_last);
        if (sub_chunk_start_o) begin
          pop_expect(K_START, rd_sel_o);
          if (mon_sub != 0) chk("start_after_end", cyc, last_end_cyc + 1);
          if (first_start_cyc < 0) first_start_cyc = cyc;
          mon_sub = (mon_sub + 1) % SUBN;
          n_start++;
        end
        if (chunk_done_o) begin
          pop_expect(K_CHUNK, rd_sel_o);
          chk("chunk_done_latency", cyc, last_end_cyc + 1);
          rel_pending = 1;
        end
        if (layer_done_o) begin
          pop_expect(K_LAYER, 0);
          n_layer++;
        end
      end
    end
  end

  // Input-selector stand-in: ends each sub-chunk 0..3 cycles after its start pulse.
  initial begin
    sub_chunk_end_i = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) sel_cnt = -1;
      else if (sub_chunk_start_o) sel_cnt = sel_zero ? 0 : int'($urandom_range(0, 3));
      #1;
      if (sel_cnt == 0) begin
        sub_chunk_end_i = 1;
        last_end_cyc = cyc;
        sel_cnt = -1;
      end else begin
        sub_chunk_end_i = 0;
        if (sel_cnt > 0) sel_cnt--;
      end
    end
  end

  // One cycle of stimulus; the model applies writes against pre-release flags, then the release.
  task automatic step(input bit wi, input bit wf, input bit en, input int cfg);
    bit a, b;
    @(negedge clk_i);
    #1;
    a = wi;
    b = wf;
    if (auto_fill) begin
      if (!m_ifm_full[m_ifm_ws] && $urandom_range(3) != 0) a = 1;
      if (!m_fil_full[m_fil_ws] && $urandom_range(3) != 0) b = 1;
    end
    if (poke && rel_pending) a = 1;
    if (stray_ok && n_layer == stray_ref) begin
      en  = ($urandom_range(7) == 0);
      cfg = int'($urandom_range(0, 3));
    end
    if (a) begin
      if (m_ifm_full[m_ifm_ws]) m_err = 1;
      else begin m_ifm_full[m_ifm_ws] = 1; m_ifm_ws = !m_ifm_ws; end
    end
    if (b) begin
      if (m_fil_full[m_fil_ws]) m_err = 1;
      else begin m_fil_full[m_fil_ws] = 1; m_fil_ws = !m_fil_ws; end
    end
    if (rel_pending) begin
      m_ifm_full[m_rd] = 0;
      m_fil_full[m_rd] = 0;
      m_rd = !m_rd;
      rel_pending = 0;
    end
    ifm_wr_done_i   = a;
    fil_wr_done_i   = b;
    enable_i        = en;
    cfg_chunk_num_i = CW'(cfg);
    cfg_fil_last_i  = AW'($urandom_range(3));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #1;
    rst_i = 1; enable_i = 0; ifm_wr_done_i = 0; fil_wr_done_i = 0;
    cfg_chunk_num_i = '0; cfg_fil_last_i = '0;
    model_reset();
    @(negedge clk_i);
    #1;
    chk("reset_outputs",
        {busy_o, err_o, rd_sel_o, ifm_wr_sel_o, fil_wr_sel_o, sub_chunk_start_o, run_valid_o,
         chunk_done_o, layer_done_o, ifm_wr_ready_o, fil_wr_ready_o, rd_fil_last_o}, 'h00C);
    rst_i = 0;
  endtask

  // Expected events for a whole layer: SUBN starts per chunk on alternating banks.
  task automatic start_layer(input int cfg, input bit wi, input bit wf);
    int rd = m_rd;
    for (int k = 0; k < cfg; k++) begin
      for (int s = 0; s < SUBN; s++) exp_q.push_back('{K_START, (rd + k) % 2});
      exp_q.push_back('{K_CHUNK, (rd + k) % 2});
    end
    exp_q.push_back('{K_LAYER, 0});
    first_start_cyc = -1;
    step(wi, wf, 1, cfg);
    if (cfg != 0) m_fil_last = cfg_fil_last_i;
  endtask

  task automatic wait_layer(input string name, input int budget);
    int n0 = n_layer;
    int t  = 0;
    bit timed_out;
    stray_ok  = 1;
    stray_ref = n0;
    while (n_layer == n0 && t < budget) begin
      step(0, 0, 0, 0);
      t++;
    end
    stray_ok = 0;
    timed_out = (n_layer == n0);
    if (timed_out) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no layer_done within %0d cycles", name, budget);
    end
    step(0, 0, 0, 0);
    chk({name, "_events_left"}, exp_q.size(), 0);
    if (timed_out) do_reset();
  endtask

  initial begin
    int c0, n0;
    rst_i = 1; enable_i = 0; ifm_wr_done_i = 0; fil_wr_done_i = 0;
    cfg_chunk_num_i = '0; cfg_fil_last_i = '0;
    auto_fill = 0; poke = 0; sel_zero = 0; stray_ok = 0;
    model_reset();
    do_reset();

    // 1: single chunk, both writes with enable; start two cycles later.
    start_layer(1, 1, 1);
    c0 = cyc;
    wait_layer("t1", 100);
    chk("t1_start_latency", first_start_cyc, c0 + 2);

    // 2: three chunks with the writer keeping banks full.
    do_reset();
    auto_fill = 1;
    n0 = n_start;
    start_layer(3, 0, 0);
    wait_layer("t2", 300);
    auto_fill = 0;
    chk("t2_starts", n_start - n0, 3 * SUBN);
    chk("t2_rd_sel_end", rd_sel_o, 1);

    // 3: IFM only -> hold in WAIT; filter later -> start follows.
    do_reset();
    n0 = n_start;
    start_layer(1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("t3_no_start", n_start - n0, 0);
    chk("t3_busy_waiting", busy_o, 1);
    step(0, 1, 0, 0);
    c0 = cyc;
    for (int i = 0; i < 10 && first_start_cyc < 0; i++) step(0, 0, 0, 0);
    chk("t3_start_latency", first_start_cyc, c0 + 2);
    wait_layer("t3", 100);

    // 4: third write-done with both banks full is rejected and sticky.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t4_err", err_o, 1);
    chk("t4_ifm_wr_sel", ifm_wr_sel_o, 0);
    chk("t4_ifm_ready", ifm_wr_ready_o, 0);
    start_layer(2, 0, 0);
    wait_layer("t4", 150);
    chk("t4_err_sticky", err_o, 1);

    // 5: sub-chunk end in every start cycle.
    do_reset();
    sel_zero = 1; auto_fill = 1;
    n0 = n_start;
    start_layer(2, 0, 0);
    wait_layer("t5", 200);
    sel_zero = 0; auto_fill = 0;
    chk("t5_starts", n_start - n0, 2 * SUBN);

    // 7: write-done into the releasing bank errors; into the other bank is accepted.
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    poke = 1;
    start_layer(2, 0, 0);
    wait_layer("t7", 150);
    poke = 0;
    chk("t7_err", err_o, 1);
    chk("t7_ifm_wr_sel", ifm_wr_sel_o, 1);
    chk("t7_rd_sel", rd_sel_o, 0);

    // Randomized layers.
    do_reset();
    auto_fill = 1;
    for (int l = 0; l < 5; l++) begin
      start_layer(int'($urandom_range(1, 5)), 0, 0);
      wait_layer("rand", 600);
    end
    auto_fill = 0;

    // 6: reset mid-run, then a zero-chunk layer.
    auto_fill = 1;
    n0 = n_start;
    start_layer(3, 0, 0);
    for (int i = 0; i < 100 && n_start < n0 + 2; i++) step(0, 0, 0, 0);
    chk("t6_reached_run", run_valid_o, 1);
    auto_fill = 0;
    do_reset();
    n0 = n_layer;
    start_layer(0, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_zero_layer_done", n_layer - n0, 1);
    chk("t6_zero_busy", busy_o, 0);
    chk("t6_events_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
